// File: rtl/captura_clave_pkg.sv
// Shared types and ASCII constants for the keypad key-capture block.
package captura_clave_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENTRY = 2'd1,
        READY = 2'd2
    } estado_t;

    typedef enum logic [1:0] {
        DIGITO  = 2'd0,
        CLEAR   = 2'd1,
        SUBMIT  = 2'd2,
        NINGUNA = 2'd3
    } tecla_t;

    localparam logic [6:0] ASCII_AST  = 7'h2A;
    localparam logic [6:0] ASCII_HASH = 7'h23;
    localparam logic [6:0] ASCII_0    = 7'h30;
    localparam logic [6:0] ASCII_9    = 7'h39;
    localparam logic [6:0] ASCII_A    = 7'h41;
    localparam logic [6:0] ASCII_D    = 7'h44;

endpackage

// File: rtl/captura_clave_decodificador.sv
// Combinational ASCII-to-key decoder: classifies a keypad code and extracts its hex nibble.
module decodificador_tecla
    import captura_clave_pkg::*;
(
    input  logic [6:0] ascii_s,
    output tecla_t     kind_s,
    output logic [3:0] nibble_s
);

    // Classify the code; 'A'..'D' have low nibbles 1..4, so adding 9 yields 0xA..0xD.
    always_comb begin
        kind_s   = NINGUNA;
        nibble_s = 4'h0;
        if ((ascii_s >= ASCII_0) && (ascii_s <= ASCII_9)) begin
            kind_s   = DIGITO;
            nibble_s = ascii_s[3:0];
        end else if ((ascii_s >= ASCII_A) && (ascii_s <= ASCII_D)) begin
            kind_s   = DIGITO;
            nibble_s = ascii_s[3:0] + 4'd9;
        end else if (ascii_s == ASCII_AST) begin
            kind_s   = CLEAR;
            nibble_s = 4'h0;
        end else if (ascii_s == ASCII_HASH) begin
            kind_s   = SUBMIT;
            nibble_s = 4'h0;
        end else begin
            kind_s   = NINGUNA;
            nibble_s = 4'h0;
        end
    end

endmodule

// File: rtl/captura_clave.sv
// Keypad key capture: packs hex digits from ASCII key events and offers the key on '#'.
// Optional ENTRY idle timeout is built when CAPTURA_CLAVE_TIMEOUT_EN is defined.
module captura_clave
    import captura_clave_pkg::*;
#(
    parameter int MAX_DIGITS     = 8,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  ascii_i,
    input  logic        tecla_valid_i,
    output logic [31:0] clave_o,
    output logic        clave_valid_o,
    input  logic        clave_ack_i,
    output logic [3:0]  digitos_o,
    output logic        error_o
);

    localparam logic [3:0] MAX_D = 4'(MAX_DIGITS);

    if ((MAX_DIGITS < 1) || (MAX_DIGITS > 8) || (TIMEOUT_CYCLES < 1)) begin : g_param_check
        $error("captura_clave: MAX_DIGITS or TIMEOUT_CYCLES out of range");
    end

    estado_t     state_r, next_state_s;
    tecla_t      kind_s;
    logic [3:0]  nibble_s;
    logic        tecla_prev_r, armed_r;
    logic        event_s, digit_ev_s, clear_ev_s, submit_ev_s, timeout_s;
    logic [31:0] shift_r, shift_nxt_s, clave_r, clave_nxt_s;
    logic [3:0]  digitos_r, digitos_nxt_s;
    logic        valid_r, valid_nxt_s, error_r, error_nxt_s;

    decodificador_tecla u_dec (
        .ascii_s  (ascii_i),
        .kind_s   (kind_s),
        .nibble_s (nibble_s)
    );

    // armed_r masks the first cycle after reset so a level already high is not an edge.
    assign event_s     = tecla_valid_i & ~tecla_prev_r & armed_r;
    assign digit_ev_s  = event_s && (kind_s == DIGITO);
    assign clear_ev_s  = event_s && (kind_s == CLEAR);
    assign submit_ev_s = event_s && (kind_s == SUBMIT);

    // Edge-detector history and post-reset arming.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tecla_prev_r <= 1'b0;
            armed_r      <= 1'b0;
        end else begin
            tecla_prev_r <= tecla_valid_i;
            armed_r      <= 1'b1;
        end
    end

`ifdef CAPTURA_CLAVE_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic          key_ev_s;
    logic [TW-1:0] timer_r, timer_nxt_s;

    assign key_ev_s  = digit_ev_s | clear_ev_s | submit_ev_s;
    assign timeout_s = (state_r == ENTRY) && !key_ev_s && (timer_r == T_LAST);

    // Idle counter: advances only while ENTRY sits without a decoded key.
    always_comb begin
        if ((state_r == ENTRY) && !key_ev_s && !timeout_s) begin
            timer_nxt_s = timer_r + TW'(1);
        end else begin
            timer_nxt_s = '0;
        end
    end

    // Idle counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer_r <= '0;
        end else begin
            timer_r <= timer_nxt_s;
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic; an overflow digit keeps ENTRY.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (digit_ev_s) next_state_s = ENTRY;
                else            next_state_s = IDLE;
            end
            ENTRY: begin
                if (clear_ev_s || timeout_s) next_state_s = IDLE;
                else if (submit_ev_s)        next_state_s = READY;
                else                         next_state_s = ENTRY;
            end
            READY: begin
                if (clave_ack_i) next_state_s = IDLE;
                else             next_state_s = READY;
            end
            default: next_state_s = IDLE;
        endcase
    end

    // FSM output logic: next values of the shift register, key, count and error pulse.
    always_comb begin
        shift_nxt_s   = shift_r;
        digitos_nxt_s = digitos_r;
        clave_nxt_s   = clave_r;
        valid_nxt_s   = valid_r;
        error_nxt_s   = 1'b0;
        case (state_r)
            IDLE, ENTRY: begin
                if (digit_ev_s) begin
                    if (digitos_r < MAX_D) begin
                        shift_nxt_s   = {shift_r[27:0], nibble_s};
                        digitos_nxt_s = digitos_r + 4'd1;
                    end else begin
                        error_nxt_s = 1'b1;
                    end
                end else if (clear_ev_s || timeout_s) begin
                    shift_nxt_s   = 32'h0;
                    digitos_nxt_s = 4'd0;
                    error_nxt_s   = timeout_s;
                end else if (submit_ev_s) begin
                    if (state_r == ENTRY) begin
                        clave_nxt_s   = shift_r;
                        valid_nxt_s   = 1'b1;
                        shift_nxt_s   = 32'h0;
                        digitos_nxt_s = 4'd0;
                    end else begin
                        error_nxt_s = 1'b1;
                    end
                end else begin
                    shift_nxt_s = shift_r;
                end
            end
            READY: begin
                if (clave_ack_i) valid_nxt_s = 1'b0;
                else             valid_nxt_s = 1'b1;
            end
            default: begin
                shift_nxt_s   = 32'h0;
                digitos_nxt_s = 4'd0;
                valid_nxt_s   = 1'b0;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_r   <= 32'h0;
            digitos_r <= 4'd0;
            clave_r   <= 32'h0;
            valid_r   <= 1'b0;
            error_r   <= 1'b0;
        end else begin
            shift_r   <= shift_nxt_s;
            digitos_r <= digitos_nxt_s;
            clave_r   <= clave_nxt_s;
            valid_r   <= valid_nxt_s;
            error_r   <= error_nxt_s;
        end
    end

    assign clave_o       = clave_r;
    assign clave_valid_o = valid_r;
    assign digitos_o     = digitos_r;
    assign error_o       = error_r;

endmodule

// File: tb/tb_captura_clave.sv
// Randomized self-checking bench for captura_clave against a queue-based key model.
module tb_captura_clave;

    localparam int MAXD = 8;
    localparam int TOC  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  ascii_i;
    logic        tecla_valid_i;
    logic [31:0] clave_o;
    logic        clave_valid_o;
    logic        clave_ack_i;
    logic [3:0]  digitos_o;
    logic        error_o;

    int vectors = 0;
    int miscompares = 0;
    int err_cnt = 0;

    int          mdig[$];
    bit          moff;
    logic [31:0] mkey;

    captura_clave #(.MAX_DIGITS(MAXD), .TIMEOUT_CYCLES(TOC)) dut (
        .clk           (clk),
        .reset         (reset),
        .ascii_i       (ascii_i),
        .tecla_valid_i (tecla_valid_i),
        .clave_o       (clave_o),
        .clave_valid_o (clave_valid_o),
        .clave_ack_i   (clave_ack_i),
        .digitos_o     (digitos_o),
        .error_o       (error_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (error_o === 1'b1) err_cnt++;

    function automatic logic [38:0] exp_vec(input int e);
        return {mkey, moff, 4'(mdig.size()), 2'(e)};
    endfunction

    function automatic logic [38:0] obs_vec(input int ed);
        return {clave_o, clave_valid_o, digitos_o, 2'(ed)};
    endfunction

    task automatic model_reset();
        mdig.delete();
        moff = 1'b0;
        mkey = 32'h0;
    endtask

    task automatic model_key(input int ch, output int e);
        e = 0;
        if (moff) return;
        if ((ch >= 48 && ch <= 57) || (ch >= 65 && ch <= 68)) begin
            if (mdig.size() < MAXD) mdig.push_back((ch <= 57) ? ch - 48 : ch - 55);
            else e = 1;
        end else if (ch == 42) begin
            mdig.delete();
        end else if (ch == 35) begin
            if (mdig.size() == 0) e = 1;
            else begin
                mkey = 32'h0;
                foreach (mdig[i]) mkey = mkey * 32'd16 + 32'(mdig[i]);
                moff = 1'b1;
                mdig.delete();
            end
        end
    endtask

    task automatic press(input int ch, input int hold, output int ed);
        int e0;
        @(negedge clk);
        e0 = err_cnt;
        ascii_i = 7'(ch);
        tecla_valid_i = 1'b1;
        repeat (hold) @(negedge clk);
        tecla_valid_i = 1'b0;
        repeat (2) @(negedge clk);
        ed = err_cnt - e0;
    endtask

    task automatic do_ack();
        @(negedge clk);
        clave_ack_i = 1'b1;
        @(negedge clk);
        clave_ack_i = 1'b0;
        @(negedge clk);
        moff = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; tecla_valid_i = 1'b0; clave_ack_i = 1'b0; ascii_i = 7'h0;
        model_reset();
        #12;
        vectors++;
        if (obs_vec(int'(error_o)) !== exp_vec(0)) begin
            miscompares++;
            $display("FAIL reset_hold got=%h want=%h", obs_vec(int'(error_o)), exp_vec(0));
        end
        @(negedge clk); reset = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if (obs_vec(int'(error_o)) !== exp_vec(0)) begin
            miscompares++;
            $display("FAIL reset_release got=%h want=%h", obs_vec(int'(error_o)), exp_vec(0));
        end
    endtask

    task automatic test_basic();
        string s = "1234#";
        int e, ed;
        for (int i = 0; i < s.len(); i++) begin
            model_key(int'(s[i]), e);
            press(int'(s[i]), 1, ed);
            vectors++;
            if (obs_vec(ed) !== exp_vec(e)) begin
                miscompares++;
                $display("FAIL basic key=%c got=%h want=%h", s[i], obs_vec(ed), exp_vec(e));
            end
        end
        repeat (4) @(negedge clk);
        vectors++;
        if ({clave_o, clave_valid_o} !== {32'h00001234, 1'b1}) begin
            miscompares++;
            $display("FAIL basic_held got=%h/%b want=00001234/1", clave_o, clave_valid_o);
        end
        do_ack();
        vectors++;
        if (obs_vec(0) !== exp_vec(0)) begin
            miscompares++;
            $display("FAIL basic_ack got=%h want=%h", obs_vec(0), exp_vec(0));
        end
    endtask

    task automatic test_overflow();
        string s = "987654321#";
        int e, ed;
        for (int i = 0; i < s.len(); i++) begin
            model_key(int'(s[i]), e);
            press(int'(s[i]), 1, ed);
            vectors++;
            if (obs_vec(ed) !== exp_vec(e)) begin
                miscompares++;
                $display("FAIL overflow key=%c got=%h want=%h", s[i], obs_vec(ed), exp_vec(e));
            end
        end
        vectors++;
        if (clave_o !== 32'h98765432) begin
            miscompares++;
            $display("FAIL overflow_key got=%h want=98765432", clave_o);
        end
        do_ack();
    endtask

    task automatic test_clear();
        string s = "5*#";
        int e, ed;
        for (int i = 0; i < s.len(); i++) begin
            model_key(int'(s[i]), e);
            press(int'(s[i]), 1, ed);
            vectors++;
            if (obs_vec(ed) !== exp_vec(e)) begin
                miscompares++;
                $display("FAIL clear key=%c got=%h want=%h", s[i], obs_vec(ed), exp_vec(e));
            end
        end
    endtask

    task automatic test_ready_drop();
        string s = "3#7#";
        int e, ed;
        for (int i = 0; i < s.len(); i++) begin
            model_key(int'(s[i]), e);
            press(int'(s[i]), 1, ed);
            vectors++;
            if (obs_vec(ed) !== exp_vec(e)) begin
                miscompares++;
                $display("FAIL ready_drop key=%c got=%h want=%h", s[i], obs_vec(ed), exp_vec(e));
            end
        end
        // key arriving in the same cycle as the ack is dropped
        @(negedge clk);
        ascii_i = 7'h37; tecla_valid_i = 1'b1; clave_ack_i = 1'b1;
        @(negedge clk);
        clave_ack_i = 1'b0; tecla_valid_i = 1'b0;
        repeat (2) @(negedge clk);
        moff = 1'b0;
        vectors++;
        if (obs_vec(0) !== exp_vec(0) || clave_o !== 32'h3) begin
            miscompares++;
            $display("FAIL ack_same_cycle got=%h want=%h", obs_vec(0), exp_vec(0));
        end
        s = "4";
        model_key(int'(s[0]), e);
        press(int'(s[0]), 1, ed);
        do_ack();
        moff = 1'b0;
        s = "*7#";
        for (int i = 0; i < s.len(); i++) begin
            model_key(int'(s[i]), e);
            press(int'(s[i]), 1, ed);
            vectors++;
            if (obs_vec(ed) !== exp_vec(e)) begin
                miscompares++;
                $display("FAIL ack_ignored key=%c got=%h want=%h", s[i], obs_vec(ed), exp_vec(e));
            end
        end
        vectors++;
        if (clave_o !== 32'h00000007) begin
            miscompares++;
            $display("FAIL ready_new_key got=%h want=00000007", clave_o);
        end
        do_ack();
    endtask

    task automatic test_hold_and_timeout();
        int e, ed, e0;
        model_key(55, e);
        press(55, 20, ed);
        vectors++;
        if (obs_vec(ed) !== exp_vec(e)) begin
            miscompares++;
            $display("FAIL hold got=%h want=%h", obs_vec(ed), exp_vec(e));
        end
        model_key(42, e);
        press(42, 1, ed);
        model_key(65, e);
        press(65, 1, ed);
        e0 = err_cnt;
`ifdef CAPTURA_CLAVE_TIMEOUT_EN
        repeat (7) @(negedge clk);
        vectors++;
        if (obs_vec(err_cnt - e0) !== exp_vec(0)) begin
            miscompares++;
            $display("FAIL timeout_early got=%h want=%h", obs_vec(err_cnt - e0), exp_vec(0));
        end
        repeat (2) @(negedge clk);
        mdig.delete();
        vectors++;
        if (obs_vec(err_cnt - e0) !== exp_vec(1)) begin
            miscompares++;
            $display("FAIL timeout got=%h want=%h", obs_vec(err_cnt - e0), exp_vec(1));
        end
`else
        repeat (30) @(negedge clk);
        vectors++;
        if (obs_vec(err_cnt - e0) !== exp_vec(0)) begin
            miscompares++;
            $display("FAIL no_timeout got=%h want=%h", obs_vec(err_cnt - e0), exp_vec(0));
        end
        model_key(42, e);
        press(42, 1, ed);
`endif
    endtask

    task automatic test_reset_level();
        int e, ed;
        @(negedge clk);
        reset = 1'b0; ascii_i = 7'h33; tecla_valid_i = 1'b1;
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        tecla_valid_i = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (obs_vec(0) !== exp_vec(0)) begin
            miscompares++;
            $display("FAIL reset_level got=%h want=%h", obs_vec(0), exp_vec(0));
        end
        model_key(51, e);
        press(51, 1, ed);
        vectors++;
        if (obs_vec(ed) !== exp_vec(e)) begin
            miscompares++;
            $display("FAIL post_reset_key got=%h want=%h", obs_vec(ed), exp_vec(e));
        end
    endtask

    task automatic test_reset_mid();
        string s = "12";
        int e, ed;
        model_key(42, e);
        press(42, 1, ed);
        for (int i = 0; i < s.len(); i++) begin
            model_key(int'(s[i]), e);
            press(int'(s[i]), 1, ed);
        end
        @(negedge clk);
        #2 reset = 1'b0;
        model_reset();
        #1;
        vectors++;
        if (obs_vec(int'(error_o)) !== exp_vec(0)) begin
            miscompares++;
            $display("FAIL reset_mid got=%h want=%h", obs_vec(int'(error_o)), exp_vec(0));
        end
        @(negedge clk); reset = 1'b1;
        s = "5#";
        for (int i = 0; i < s.len(); i++) begin
            model_key(int'(s[i]), e);
            press(int'(s[i]), 1, ed);
        end
        @(negedge clk);
        #2 reset = 1'b0;
        model_reset();
        #1;
        vectors++;
        if (obs_vec(int'(error_o)) !== exp_vec(0)) begin
            miscompares++;
            $display("FAIL reset_ready got=%h want=%h", obs_vec(int'(error_o)), exp_vec(0));
        end
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_random();
`ifdef CAPTURA_CLAVE_TIMEOUT_EN
        string pool = "0123456789ABCD*##";
`else
        string pool = "0123456789ABCD*##E/x@";
`endif
        int e, ed, ch;
        for (int n = 0; n < 80; n++) begin
            if (moff && ($urandom_range(0, 2) == 0)) begin
                do_ack();
                vectors++;
                if (obs_vec(0) !== exp_vec(0)) begin
                    miscompares++;
                    $display("FAIL random_ack n=%0d got=%h want=%h", n, obs_vec(0), exp_vec(0));
                end
            end else begin
                ch = int'(pool[$urandom_range(0, pool.len() - 1)]);
                model_key(ch, e);
                press(ch, $urandom_range(1, 3), ed);
                vectors++;
                if (obs_vec(ed) !== exp_vec(e)) begin
                    miscompares++;
                    $display("FAIL random n=%0d key=%c got=%h want=%h", n, 8'(ch), obs_vec(ed), exp_vec(e));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_clear();
        test_ready_drop();
        test_hold_and_timeout();
        test_reset_level();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
